bcd_time_keeper: RTL and testbench
==================================

// Module: bcd_time_keeper
// PURPOSE
//  Time-of-day core of the alarm clock. Sits directly downstream of the 1 Hz prescaler counter.
//  Consumes its one-cycle 'tick' pulse and keeps HH:MM:SS in BCD, 24-hour format.
//  Accepts validated time/alarm loads and runs the alarm ring state machine.
//  Drives the display mux and buzzer logic.
// PARAMETERS
//  RING_TIMEOUT_S  60  ticks spent in RINGING before auto-stop; 0 = ring until ack/disable
//  RING_CNT_W      8   width of ring timeout counter; must hold RING_TIMEOUT_S
// PORTS
//  clk        in   1   system clock
//  reset      in   1   synchronous, active-high reset
//  tick       in   1   1-cycle pulse, once per second, from prescaler
//  set_time   in   1   1-cycle strobe: load set_val into time
//  set_val    in   24  {Ht,Hu,Mt,Mu,St,Su} BCD nibbles
//  set_alarm  in   1   1-cycle strobe: load alarm_val into alarm register
//  alarm_val  in   16  {Ht,Hu,Mt,Mu} BCD nibbles
//  alarm_en   in   1   level: alarm armed
//  alarm_ack  in   1   1-cycle strobe: silence ringing alarm
//  time_bcd   out  24  current time, registered, same packing as set_val
//  alarm_bcd  out  16  current alarm setting, registered
//  ringing    out  1   level: alarm ringing (FSM in RINGING)
//  min_tick   out  1   1-cycle pulse on the edge where SS wraps 59->00 from a tick
//  set_err    out  1   1-cycle pulse: a set strobe carried an invalid BCD value
// BEHAVIOUR
//  Reset (sync, rising edge with reset=1) sets these values:
//   - time_bcd = 24'h000000, alarm_bcd = 16'h0000
//   - ringing = 0, min_tick = 0, set_err = 0
//   - FSM = IDLE, ring counter = 0
//   - reset overrides every other input in that cycle, including mid-RINGING
//  Time advance:
//   - tick=1 updates time_bcd at the same edge (1-cycle latency to output)
//   - Su 9->0 carries to St; St 5->0 carries to Mu; Mu 9->0 carries to Mt; Mt 5->0 carries to hours
//   - hours: Hu 9->0 carries to Ht; 23 -> 00
//   - full wrap 23:59:59 -> 00:00:00 in one tick
//   - min_tick = 1 for exactly the cycle after a tick that produced SS=00; 0 otherwise
//  Validation, per digit:
//   - Ht<=2; Hu<=9; if Ht==2 then Hu<=3
//   - Mt<=5; Mu<=9; St<=5; Su<=9
//  Loads:
//   - set_time with valid set_val: time_bcd <= set_val next edge; a coincident tick is dropped
//   - set_time with invalid set_val: time unchanged; a coincident tick still advances time; set_err=1 for one cycle
//   - set_alarm with valid alarm_val: alarm_bcd <= alarm_val; invalid: alarm_bcd unchanged, set_err pulse
//   - both strobes in one cycle: each validated and loaded independently; set_err if either is invalid
//  Alarm FSM (IDLE, RINGING):
//   - IDLE->RINGING when alarm_en=1 AND a tick advances time to {alarm_bcd,8'h00}; ringing rises on the same edge
//   - a set_time load equal to the alarm time never triggers RINGING
//   - RINGING->IDLE on any of: alarm_ack=1; alarm_en=0; the tick that brings ring count to RING_TIMEOUT_S
//   - ring counter clears on entry and increments on each tick while RINGING
//   - alarm_ack in IDLE is ignored
//   - set_time and set_alarm while RINGING do not affect ringing
//   - a match and alarm_ack in the same IDLE cycle: the match wins, FSM enters RINGING
//  Arithmetic is per-nibble BCD; no binary intermediate. Outputs never show non-BCD digits.
// TESTING
//  1. reset mid-count -> time_bcd=000000, alarm_bcd=0000, ringing=0 on next edge
//  2. set_time 235958, then 2 ticks -> 235959, then 000000; min_tick pulses once, in the cycle after the second tick
//  3. set_time 245000 -> set_err one cycle, time unchanged; set_alarm 0760 -> set_err, alarm unchanged
//  4. alarm 0700, en=1, time 065959, tick -> time 070000 and ringing=1 same edge; alarm_ack -> ringing=0 next edge
//  5. RING_TIMEOUT_S=3, alarm fires, no ack -> ringing drops on the edge of the 3rd subsequent tick
//  6. set_time 070000 with alarm 0700 en=1 -> no ring; tick coincident with valid set_time -> loaded value wins

Source files
------------

// File: rtl/bcd_time_keeper.sv
// Time-of-day keeper: BCD HH:MM:SS (24 h) advanced by a 1 Hz tick, validated time/alarm
// loads, and a two-state alarm ring machine with optional tick-counted auto-stop.
module bcd_time_keeper #(
    parameter int unsigned RING_TIMEOUT_S = 60,
    parameter int unsigned RING_CNT_W     = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick,
    input  logic        set_time,
    input  logic [23:0] set_val,
    input  logic        set_alarm,
    input  logic [15:0] alarm_val,
    input  logic        alarm_en,
    input  logic        alarm_ack,
    output logic [23:0] time_bcd,
    output logic [15:0] alarm_bcd,
    output logic        ringing,
    output logic        min_tick,
    output logic        set_err
);

    typedef enum logic [0:0] {StIdle, StRinging} ring_state_e;

    localparam logic                  TimeoutOn = (RING_TIMEOUT_S != 0);
    localparam logic [RING_CNT_W-1:0] RingLimit = RING_CNT_W'(RING_TIMEOUT_S);

    // Packing {Ht,Hu,Mt,Mu,St,Su}; an alarm is checked as {alarm,8'h00}.
    function automatic logic time_is_valid(input logic [23:0] t);
        logic [3:0] ht, hu, mt, mu, st, su;
        {ht, hu, mt, mu, st, su} = t;
        return (ht <= 4'd2) && (hu <= 4'd9) && !((ht == 4'd2) && (hu > 4'd3)) &&
               (mt <= 4'd5) && (mu <= 4'd9) && (st <= 4'd5) && (su <= 4'd9);
    endfunction

    function automatic logic [23:0] bcd_inc(input logic [23:0] t);
        logic [3:0] ht, hu, mt, mu, st, su;
        {ht, hu, mt, mu, st, su} = t;
        if (su != 4'd9) begin
            su = su + 4'd1;
        end else begin
            su = 4'd0;
            if (st != 4'd5) begin
                st = st + 4'd1;
            end else begin
                st = 4'd0;
                if (mu != 4'd9) begin
                    mu = mu + 4'd1;
                end else begin
                    mu = 4'd0;
                    if (mt != 4'd5) begin
                        mt = mt + 4'd1;
                    end else begin
                        mt = 4'd0;
                        if ((ht == 4'd2) && (hu == 4'd3)) begin
                            ht = 4'd0;
                            hu = 4'd0;
                        end else if (hu == 4'd9) begin
                            hu = 4'd0;
                            ht = ht + 4'd1;
                        end else begin
                            hu = hu + 4'd1;
                        end
                    end
                end
            end
        end
        return {ht, hu, mt, mu, st, su};
    endfunction

    logic [23:0]           time_q, time_d, time_inc;
    logic [15:0]           alarm_q, alarm_d;
    ring_state_e           state_q, state_d;
    logic [RING_CNT_W-1:0] ring_cnt_q, ring_cnt_d, ring_cnt_inc;
    logic                  min_tick_q, min_tick_d;
    logic                  set_err_q, set_err_d;
    logic                  time_load_ok, alarm_load_ok, time_adv, alarm_hit;

    // Datapath: loads, time advance and the alarm match condition.
    always_comb begin
        time_inc      = bcd_inc(time_q);
        time_load_ok  = set_time && time_is_valid(set_val);
        alarm_load_ok = set_alarm && time_is_valid({alarm_val, 8'h00});
        // A valid load swallows a coincident tick; an invalid one does not.
        time_adv      = tick && !time_load_ok;
        alarm_hit     = time_adv && alarm_en && (time_inc == {alarm_q, 8'h00});

        time_d = time_q;
        if (time_load_ok) begin
            time_d = set_val;
        end else if (time_adv) begin
            time_d = time_inc;
        end

        alarm_d = alarm_q;
        if (alarm_load_ok) begin
            alarm_d = alarm_val;
        end

        min_tick_d = time_adv && (time_inc[7:0] == 8'h00);
        set_err_d  = (set_time && !time_load_ok) || (set_alarm && !alarm_load_ok);
    end

    // Alarm ring state machine.
    always_comb begin
        state_d      = state_q;
        ring_cnt_d   = ring_cnt_q;
        ring_cnt_inc = ring_cnt_q + RING_CNT_W'(1);
        unique case (state_q)
            StIdle: begin
                if (alarm_hit) begin
                    state_d    = StRinging;
                    ring_cnt_d = '0;
                end
            end
            StRinging: begin
                if (alarm_ack || !alarm_en) begin
                    state_d = StIdle;
                end else if (tick) begin
                    ring_cnt_d = ring_cnt_inc;
                    if (TimeoutOn && (ring_cnt_inc == RingLimit)) begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            time_q     <= 24'h000000;
            alarm_q    <= 16'h0000;
            state_q    <= StIdle;
            ring_cnt_q <= '0;
            min_tick_q <= 1'b0;
            set_err_q  <= 1'b0;
        end else begin
            time_q     <= time_d;
            alarm_q    <= alarm_d;
            state_q    <= state_d;
            ring_cnt_q <= ring_cnt_d;
            min_tick_q <= min_tick_d;
            set_err_q  <= set_err_d;
        end
    end

    assign time_bcd  = time_q;
    assign alarm_bcd = alarm_q;
    assign ringing   = (state_q == StRinging);
    assign min_tick  = min_tick_q;
    assign set_err   = set_err_q;

endmodule

// File: tb/tb_bcd_time_keeper.sv
// Scoreboard bench for bcd_time_keeper: each driven cycle queues its hand-computed post-edge
// outputs; a monitor pops and compares one entry per clock edge.
module tb_bcd_time_keeper;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        tick = 1'b0;
    logic        set_time = 1'b0;
    logic [23:0] set_val = '0;
    logic        set_alarm = 1'b0;
    logic [15:0] alarm_val = '0;
    logic        alarm_en = 1'b0;
    logic        alarm_ack = 1'b0;
    logic [23:0] time_bcd;
    logic [15:0] alarm_bcd;
    logic        ringing;
    logic        min_tick;
    logic        set_err;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [23:0] t;
        logic [15:0] a;
        logic        r;
        logic        m;
        logic        e;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    bcd_time_keeper #(
        .RING_TIMEOUT_S(3),
        .RING_CNT_W    (8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .tick     (tick),
        .set_time (set_time),
        .set_val  (set_val),
        .set_alarm(set_alarm),
        .alarm_val(alarm_val),
        .alarm_en (alarm_en),
        .alarm_ack(alarm_ack),
        .time_bcd (time_bcd),
        .alarm_bcd(alarm_bcd),
        .ringing  (ringing),
        .min_tick (min_tick),
        .set_err  (set_err)
    );

    task automatic check(input string name, input int step_no, input logic [23:0] act,
                         input logic [23:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s step %0d: got %h want %h", name, step_no, act, req);
        end
    endtask

    // Monitor: one expected entry per edge, sampled just after the edge.
    int step_seen = 0;
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            step_seen++;
            check("time_bcd", step_seen, time_bcd, e.t);
            check("alarm_bcd", step_seen, {8'h00, alarm_bcd}, {8'h00, e.a});
            check("ringing", step_seen, {23'h0, ringing}, {23'h0, e.r});
            check("min_tick", step_seen, {23'h0, min_tick}, {23'h0, e.m});
            check("set_err", step_seen, {23'h0, set_err}, {23'h0, e.e});
        end
    end

    // Drive one cycle of inputs and queue the outputs expected after the following edge.
    task automatic step(input logic rs, input logic tk, input logic st, input logic [23:0] sv,
                        input logic sa, input logic [15:0] av, input logic en,
                        input logic ack, input logic [23:0] et, input logic [15:0] ea,
                        input logic er, input logic em, input logic ee);
        exp_t e;
        @(negedge clk);
        reset     = rs;
        tick      = tk;
        set_time  = st;
        set_val   = sv;
        set_alarm = sa;
        alarm_val = av;
        alarm_en  = en;
        alarm_ack = ack;
        e.t = et;
        e.a = ea;
        e.r = er;
        e.m = em;
        e.e = ee;
        exp_q.push_back(e);
    endtask

    initial begin
        //    rs tk st sv        sa av       en ack  time       alarm    r  m  e
        // Reset, some activity, reset again mid-count (also with other strobes active).
        step(1, 0, 0, 24'h0,      0, 16'h0,    0, 0, 24'h000000, 16'h0000, 0, 0, 0);
        step(0, 0, 1, 24'h123456, 0, 16'h0,    0, 0, 24'h123456, 16'h0000, 0, 0, 0);
        step(0, 1, 0, 24'h0,      0, 16'h0,    0, 0, 24'h123457, 16'h0000, 0, 0, 0);
        step(0, 1, 0, 24'h0,      0, 16'h0,    0, 0, 24'h123458, 16'h0000, 0, 0, 0);
        step(0, 0, 0, 24'h0,      1, 16'h1234, 0, 0, 24'h123458, 16'h1234, 0, 0, 0);
        step(1, 1, 1, 24'h111111, 1, 16'h2222, 0, 0, 24'h000000, 16'h0000, 0, 0, 0);
        // Full-day wrap and min_tick, plus hour/minute carries.
        step(0, 0, 1, 24'h235958, 0, 16'h0,    0, 0, 24'h235958, 16'h0000, 0, 0, 0);
        step(0, 1, 0, 24'h0,      0, 16'h0,    0, 0, 24'h235959, 16'h0000, 0, 0, 0);
        step(0, 1, 0, 24'h0,      0, 16'h0,    0, 0, 24'h000000, 16'h0000, 0, 1, 0);
        step(0, 0, 0, 24'h0,      0, 16'h0,    0, 0, 24'h000000, 16'h0000, 0, 0, 0);
        step(0, 0, 1, 24'h195959, 0, 16'h0,    0, 0, 24'h195959, 16'h0000, 0, 0, 0);
        step(0, 1, 0, 24'h0,      0, 16'h0,    0, 0, 24'h200000, 16'h0000, 0, 1, 0);
        step(0, 0, 1, 24'h095959, 0, 16'h0,    0, 0, 24'h095959, 16'h0000, 0, 0, 0);
        step(0, 1, 0, 24'h0,      0, 16'h0,    0, 0, 24'h100000, 16'h0000, 0, 1, 0);
        step(0, 0, 1, 24'h000009, 0, 16'h0,    0, 0, 24'h000009, 16'h0000, 0, 0, 0);
        step(0, 1, 0, 24'h0,      0, 16'h0,    0, 0, 24'h000010, 16'h0000, 0, 0, 0);
        // Invalid loads.
        step(0, 0, 1, 24'h245000, 0, 16'h0,    0, 0, 24'h000010, 16'h0000, 0, 0, 1);
        step(0, 0, 0, 24'h0,      0, 16'h0,    0, 0, 24'h000010, 16'h0000, 0, 0, 0);
        step(0, 0, 0, 24'h0,      1, 16'h0760, 0, 0, 24'h000010, 16'h0000, 0, 0, 1);
        step(0, 1, 1, 24'h006000, 0, 16'h0,    0, 0, 24'h000011, 16'h0000, 0, 0, 1);
        step(0, 0, 1, 24'h101010, 1, 16'h2400, 0, 0, 24'h101010, 16'h0000, 0, 0, 1);
        step(0, 0, 1, 24'h235960, 1, 16'h2359, 0, 0, 24'h101010, 16'h2359, 0, 0, 1);
        // Alarm fires, acked; ack in idle ignored; match beats ack; disable stops ring.
        step(0, 0, 0, 24'h0,      1, 16'h0700, 0, 0, 24'h101010, 16'h0700, 0, 0, 0);
        step(0, 0, 1, 24'h065959, 0, 16'h0,    1, 0, 24'h065959, 16'h0700, 0, 0, 0);
        step(0, 1, 0, 24'h0,      0, 16'h0,    1, 0, 24'h070000, 16'h0700, 1, 1, 0);
        step(0, 0, 0, 24'h0,      0, 16'h0,    1, 0, 24'h070000, 16'h0700, 1, 0, 0);
        step(0, 0, 0, 24'h0,      0, 16'h0,    1, 1, 24'h070000, 16'h0700, 0, 0, 0);
        step(0, 0, 0, 24'h0,      0, 16'h0,    1, 1, 24'h070000, 16'h0700, 0, 0, 0);
        step(0, 0, 1, 24'h065959, 0, 16'h0,    1, 0, 24'h065959, 16'h0700, 0, 0, 0);
        step(0, 1, 0, 24'h0,      0, 16'h0,    1, 1, 24'h070000, 16'h0700, 1, 1, 0);
        step(0, 0, 0, 24'h0,      0, 16'h0,    0, 0, 24'h070000, 16'h0700, 0, 0, 0);
        // Timeout after 3 ticks in RINGING; loads while ringing leave it ringing.
        step(0, 0, 1, 24'h065959, 0, 16'h0,    1, 0, 24'h065959, 16'h0700, 0, 0, 0);
        step(0, 1, 0, 24'h0,      0, 16'h0,    1, 0, 24'h070000, 16'h0700, 1, 1, 0);
        step(0, 1, 0, 24'h0,      0, 16'h0,    1, 0, 24'h070001, 16'h0700, 1, 0, 0);
        step(0, 0, 1, 24'h080000, 1, 16'h0900, 1, 0, 24'h080000, 16'h0900, 1, 0, 0);
        step(0, 1, 0, 24'h0,      0, 16'h0,    1, 0, 24'h080001, 16'h0900, 1, 0, 0);
        step(0, 0, 0, 24'h0,      0, 16'h0,    1, 0, 24'h080001, 16'h0900, 1, 0, 0);
        step(0, 1, 0, 24'h0,      0, 16'h0,    1, 0, 24'h080002, 16'h0900, 0, 0, 0);
        step(0, 1, 0, 24'h0,      0, 16'h0,    1, 0, 24'h080003, 16'h0900, 0, 0, 0);
        // Reset while ringing.
        step(0, 0, 1, 24'h065959, 1, 16'h0700, 1, 0, 24'h065959, 16'h0700, 0, 0, 0);
        step(0, 1, 0, 24'h0,      0, 16'h0,    1, 0, 24'h070000, 16'h0700, 1, 1, 0);
        step(1, 1, 0, 24'h0,      0, 16'h0,    1, 0, 24'h000000, 16'h0000, 0, 0, 0);
        // Loading the alarm time never rings; a valid load drops a coincident tick.
        step(0, 0, 0, 24'h0,      1, 16'h0700, 1, 0, 24'h000000, 16'h0700, 0, 0, 0);
        step(0, 0, 1, 24'h070000, 0, 16'h0,    1, 0, 24'h070000, 16'h0700, 0, 0, 0);
        step(0, 1, 0, 24'h0,      0, 16'h0,    1, 0, 24'h070001, 16'h0700, 0, 0, 0);
        step(0, 1, 1, 24'h065959, 0, 16'h0,    1, 0, 24'h065959, 16'h0700, 0, 0, 0);
        step(0, 1, 1, 24'h065959, 0, 16'h0,    1, 0, 24'h065959, 16'h0700, 0, 0, 0);
        step(0, 1, 1, 24'h120000, 0, 16'h0,    1, 0, 24'h120000, 16'h0700, 0, 0, 0);
        step(0, 1, 0, 24'h0,      0, 16'h0,    1, 0, 24'h120001, 16'h0700, 0, 0, 0);
        step(0, 0, 0, 24'h0,      0, 16'h0,    0, 0, 24'h120001, 16'h0700, 0, 0, 0);

        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d entries left want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
